nand2_cell: RTL and testbench

Two-input NAND cell with a combinational output and a registered, change-monitored copy of that output. It is the base gate primitive of the logic-gate library. Other gates and small datapaths build on it. A vector of independent bit-slices is supported through a width parameter.

---
 rtl/nand2_cell.sv | 48 ++++
 tb/tb_nand2_cell.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/nand2_cell.sv
// nand2_cell: per-bit NAND with a registered, change-counted copy of the result.
// Define NAND2_CELL_MON_EN to build the y_q/chg/chg_cnt monitor; otherwise y_q follows y.
module nand2_cell #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             chg,
  output logic [CNT_W-1:0] chg_cnt
);
  assign y = ~(a & b);
`ifdef NAND2_CELL_MON_EN
  logic [WIDTH-1:0] yq_q;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_comb begin
    chg_d = y != yq_q;
    cnt_d = clr_cnt ? '0 : (chg_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      yq_q  <= '1;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      yq_q  <= y;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end
  assign y_q     = yq_q;
  assign chg     = chg_q;
  assign chg_cnt = cnt_q;
`else
  logic unused_mon;
  assign unused_mon = ^{clk, rst, clr_cnt};
  assign y_q        = y;
  assign chg        = 1'b0;
  assign chg_cnt    = '0;
`endif
endmodule

// File: tb/tb_nand2_cell.sv
// tb_nand2_cell: directed checks of nand2_cell against a bench-side model, both builds.
module tb_nand2_cell;
`ifdef NAND2_CELL_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a1 = 1'b1, b1 = 1'b1, clr1 = 1'b0;
  logic y1, yq1, chg1;
  logic [15:0] cnt1;
  logic [3:0] a2 = 4'h0, b2 = 4'hf;
  logic clr2 = 1'b0;
  logic [3:0] y2, yq2;
  logic chg2;
  logic [1:0] cnt2;
  int n_chk = 0, n_fail = 0, p1 = 0, p2 = 0;
  bit chk_en = 1'b0;

  nand2_cell #(.WIDTH(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .clr_cnt(clr1),
    .y(y1), .y_q(yq1), .chg(chg1), .chg_cnt(cnt1)
  );
  nand2_cell #(.WIDTH(4), .CNT_W(2)) u_d2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .clr_cnt(clr2),
    .y(y2), .y_q(yq2), .chg(chg2), .chg_cnt(cnt2)
  );

  always #5 clk = ~clk;

  // Model: last sampled NAND value, whether it differed from the previous sample, and a saturating tally.
  logic       m1_yq, m1_chg;
  logic [3:0] m2_yq;
  logic       m2_chg;
  int         m1_cnt, m2_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1_yq <= 1'b1; m1_chg <= 1'b0; m1_cnt <= 0;
      m2_yq <= 4'hf; m2_chg <= 1'b0; m2_cnt <= 0;
    end else begin
      m1_yq  <= ~(a1 & b1);
      m1_chg <= (~(a1 & b1)) != m1_yq;
      m1_cnt <= clr1 ? 0 : ((~(a1 & b1)) != m1_yq && m1_cnt < 65535) ? m1_cnt + 1 : m1_cnt;
      m2_yq  <= ~(a2 & b2);
      m2_chg <= (~(a2 & b2)) != m2_yq;
      m2_cnt <= clr2 ? 0 : ((~(a2 & b2)) != m2_yq && m2_cnt < 3) ? m2_cnt + 1 : m2_cnt;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chg1 === 1'b1) p1++;
    if (chg2 === 1'b1) p2++;
    if (chk_en) begin
      chk("y1", {31'd0, y1}, {31'd0, ~(a1 & b1)});
      chk("y2", {28'd0, y2}, {28'd0, ~(a2 & b2)});
      chk("yq1", {31'd0, yq1}, {31'd0, MON ? m1_yq : ~(a1 & b1)});
      chk("yq2", {28'd0, yq2}, {28'd0, MON ? m2_yq : ~(a2 & b2)});
      chk("chg1", {31'd0, chg1}, {31'd0, MON ? m1_chg : 1'b0});
      chk("chg2", {31'd0, chg2}, {31'd0, MON ? m2_chg : 1'b0});
      chk("cnt1", {16'd0, cnt1}, MON ? m1_cnt : 0);
      chk("cnt2", {30'd0, cnt2}, MON ? m2_cnt : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic step1(input logic a, input logic b, input logic y_exp);
    a1 = a; b1 = b;
    #1 chk("tt_y", {31'd0, y1}, {31'd0, y_exp});
    cyc(5);
    chk("tt_yq", {31'd0, yq1}, {31'd0, y_exp});
  endtask

  initial begin
    #1 rst = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_async_yq", {31'd0, yq1}, MON ? 32'd1 : 32'd0);
    cyc(2);
    chk("rst_y", {31'd0, y1}, 32'd0);
    chk("rst_yq", {31'd0, yq1}, MON ? 32'd1 : 32'd0);
    chk("rst_chg", {31'd0, chg1}, 32'd0);
    chk("rst_cnt", {16'd0, cnt1}, 32'd0);
    rst = 1'b1;
    cyc(1);
    chk("rel_chg", {31'd0, chg1}, MON ? 32'd1 : 32'd0);
    chk("rel_cnt", {16'd0, cnt1}, MON ? 32'd1 : 32'd0);
    clr1 = 1'b1;
    cyc(1);
    clr1 = 1'b0;
    chk("clr_cnt1", {16'd0, cnt1}, 32'd0);
    chk("clr_chg1", {31'd0, chg1}, 32'd0);
    p1 = 0;
    step1(1'b1, 1'b0, 1'b1);
    step1(1'b0, 1'b0, 1'b1);
    step1(1'b0, 1'b1, 1'b1);
    step1(1'b1, 1'b1, 1'b0);
    chk("seq_pulses", p1, MON ? 32'd2 : 32'd0);
    chk("seq_cnt", {16'd0, cnt1}, MON ? 32'd2 : 32'd0);
    repeat (7) begin
      a2[0] = ~a2[0];
      cyc(1);
    end
    chk("sat_cnt", {30'd0, cnt2}, MON ? 32'd3 : 32'd0);
    chk("sat_chg", {31'd0, chg2}, MON ? 32'd1 : 32'd0);
    a2[0] = ~a2[0];
    clr2 = 1'b1;
    cyc(1);
    clr2 = 1'b0;
    chk("satclr_cnt", {30'd0, cnt2}, 32'd0);
    chk("satclr_chg", {31'd0, chg2}, MON ? 32'd1 : 32'd0);
    a2 = 4'b1100; b2 = 4'b1010;
    #1 chk("vec_y", {28'd0, y2}, 32'h7);
    cyc(3);
    p2 = 0;
    a2 = 4'b1110;
    #1 chk("vec_y1", {28'd0, y2}, 32'h5);
    cyc(5);
    chk("vec_pulses", p2, MON ? 32'd1 : 32'd0);
    chk("vec_yq", {28'd0, yq2}, 32'h5);
    #1 rst = 1'b0;
    #1 chk("mid_rst_yq", {31'd0, yq1}, MON ? 32'd1 : 32'd0);
    chk("mid_rst_cnt", {16'd0, cnt1}, 32'd0);
    chk("mid_rst_chg", {31'd0, chg1}, 32'd0);
    chk("mid_rst_cnt2", {30'd0, cnt2}, 32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
